xadac_exe_arbiter: RTL
======================

# xadac_exe_arbiter

Shares one xadac execute unit between `NoMst` requesters (e.g. two issue ports or core plus DMA-style sequencer). Requests are granted round-robin and forwarded to the single downstream `xadac_exe_if`. Responses are routed back to the originating requester by an in-order source-index FIFO. The arbiter sits between the requesters' `xadac_exe_if.mst` ports and the execute unit's `xadac_exe_if.slv` port and adds no latency on either path.

## Interface
- `NoMst`, 2: number of requesters, ≥2.
- `Depth`, 4: maximum outstanding (accepted, unanswered) requests, ≥1.

- `clk_i`  in  1  single clock, all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `slv_exe[NoMst]`  xadac_exe_if.slv  struct  requester-facing ports; requester `i` drives `req`/`req_valid`/`rsp_ready`.
- `mst_exe`  xadac_exe_if.mst  struct  toward the execute unit.

## Operation
- Downstream unit returns responses strictly in request-acceptance order. This is a requirement on the unit; the arbiter relies on it.
- State: `rr_q` (clog2(NoMst) bits), `lock_q` (1), `gnt_q` (clog2(NoMst)), FIFO of source indices with `cnt_q` (clog2(Depth+1) bits).
- Grant, when `lock_q`=0: first index `i` ≥ `rr_q` with `slv_exe[i].req_valid`, searching upward with wrap to 0. When `lock_q`=1: `gnt_q`.
- `full` = (`cnt_q`==Depth). Full is judged on the registered count. A same-cycle pop does not free a slot for a push.
- `mst_exe.req` = `slv_exe[gnt].req`, unmodified, including `id`.
- `mst_exe.req_valid` = `slv_exe[gnt].req_valid` & !full.
- `slv_exe[gnt].req_ready` = `mst_exe.req_ready` & !full. All other `req_ready` = 0.
- Lock: if `mst_exe.req_valid` & !`mst_exe.req_ready`, set `lock_q`=1 and `gnt_q`=gnt. The grant must not change while a forwarded request is pending.
- Accept (`mst_exe.req_valid` & `req_ready`):
  - push gnt into FIFO;
  - `rr_q` ← (gnt+1) mod NoMst;
  - `lock_q` ← 0.
- Response routing: head = FIFO head index when `cnt_q`>0.
  - `slv_exe[head].rsp` = `mst_exe.rsp`.
  - `slv_exe[head].rsp_valid` = `mst_exe.rsp_valid` & (`cnt_q`>0).
  - `mst_exe.rsp_ready` = `slv_exe[head].rsp_ready` & (`cnt_q`>0).
  - Non-head `rsp_valid` = 0.
- Pop on `mst_exe.rsp_valid` & `rsp_ready`.
- Push and pop in the same cycle: `cnt_q` unchanged, pointers both advance.
- `mst_exe.rsp_valid` while `cnt_q`==0 is a protocol error:
  - `rsp_ready` stays 0;
  - nothing is routed;
  - a simulation assertion fires.
- Requester withdrawing `req_valid` while locked violates the handshake rule; an assertion checks it.

## Timing
- Request path: combinational, 0 cycles requester→unit.
- Response path: combinational, 0 cycles unit→requester.
- FIFO/count/rr/lock update on the accepting edge. A request accepted in cycle N can have its response routed in cycle N+1 at the earliest.
- Reset (async assert, any time):
  - `rr_q`=0, `lock_q`=0, `gnt_q`=0, `cnt_q`=0, FIFO pointers 0.
  - All `req_ready`, `rsp_valid`, `mst_exe.req_valid`, `mst_exe.rsp_ready` = 0.
  - Outstanding entries are discarded; the execute unit must be reset together with the arbiter.
- Pointer wrap: read/write pointers wrap modulo Depth. Non-power-of-two Depth is supported by an explicit compare-and-clear.
- Sustained throughput: one request and one response per cycle while not full.

## Structure
- `IdT`, `InstrT`, `XlenT`, `VectorT`, `RegIdT`, `NoRs`, `NoVs` stay in `xadac_pkg`. The arbiter adds no package types.
- The source-index type is a local `logic [$clog2(NoMst)-1:0]`.
- Sub-module `xadac_idx_fifo` (parameters `Width`, `Depth`; push/pop/full/empty/head). It is reusable for other xadac in-order routing.
- Round-robin select is a function inside the arbiter.

## Test plan
- Single requester: NoMst=2, only port 1 valid, unit ready, id=5 → forwarded same cycle. Response with id=5 is returned on port 1 only; `cnt_q` goes 0→1→0.
- Fairness: both ports valid continuously, unit always ready → grants alternate 0,1,0,1; responses are routed in the same order.
- Backpressure lock: port 0 granted, unit `req_ready`=0 for 3 cycles, port 1 asserts valid meanwhile → grant stays 0 until accept, then port 1 is granted the next cycle.
- Full: Depth=4, 4 accepted and no responses → 5th request is held (`req_ready`=0). Response pop in the same cycle still blocks the push; the push is accepted the following cycle.
- Simultaneous push/pop at `cnt_q`=2 → `cnt_q` stays 2 and the head advances correctly across pointer wrap.
- Reset mid-operation: `rst_ni` low with 3 outstanding → all outputs 0 immediately. After release, first grant starts at port 0 with `cnt_q`=0.

Source files
------------

// File: rtl/xadac_pkg.sv
// Shared xadac execute-interface types used by issue ports, arbiters and execute units.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package xadac_pkg;

    localparam int unsigned NoRs = 2;
    localparam int unsigned NoVs = 1;

    typedef logic [3:0]  IdT;
    typedef logic [31:0] InstrT;
    typedef logic [31:0] XlenT;
    typedef logic [63:0] VectorT;
    typedef logic [4:0]  RegIdT;

    // Request toward the execute unit: tag, instruction word and source operands.
    typedef struct packed {
        IdT                    id;
        InstrT                 instr;
        XlenT   [NoRs-1:0]     rs;
        VectorT [NoVs-1:0]     vs;
    } exe_req_t;

    // Response from the execute unit: tag, destination and result values.
    typedef struct packed {
        IdT     id;
        RegIdT  rd;
        XlenT   data;
        VectorT vd;
    } exe_rsp_t;

endpackage

// File: rtl/xadac_exe_arbiter_fifo.sv
// Small in-order FIFO of source indices, used to route responses back to their requesters.
// Latency: push is visible at the head on the next cycle; head is combinational from the read pointer.
// Backpressure: full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
module xadac_idx_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    // Explicit compare-and-clear so that non-power-of-two depths wrap correctly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/xadac_exe_arbiter.sv
// Round-robin sharing of one xadac execute unit between NoMst requesters, with in-order response routing.
// Latency: zero cycles on both request and response paths; bookkeeping updates on the accepting edge.
// Backpressure: a stalled forwarded request locks the grant; requests stall while Depth are outstanding.
module xadac_exe_arbiter
    import xadac_pkg::*;
#(
    parameter int unsigned NoMst = 2,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // requester-facing ports
    input  exe_req_t [NoMst-1:0]   slv_req,
    input  logic     [NoMst-1:0]   slv_req_valid,
    output logic     [NoMst-1:0]   slv_req_ready,
    output exe_rsp_t [NoMst-1:0]   slv_rsp,
    output logic     [NoMst-1:0]   slv_rsp_valid,
    input  logic     [NoMst-1:0]   slv_rsp_ready,
    // execute-unit-facing port
    output exe_req_t               mst_req,
    output logic                   mst_req_valid,
    input  logic                   mst_req_ready,
    input  exe_rsp_t               mst_rsp,
    input  logic                   mst_rsp_valid,
    output logic                   mst_rsp_ready
);

    localparam int unsigned IdxW = $clog2(NoMst);
    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_q;
    logic lock_q;
    idx_t gnt_q;
    idx_t gnt;
    idx_t rr_next;
    idx_t head;
    logic full;
    logic empty;
    logic has_head;
    logic accept;
    logic pop;

    // First valid requester at or above the priority pointer, wrapping to 0.
    function automatic idx_t rr_select(input logic [NoMst-1:0] valid, input idx_t start);
        idx_t        sel;
        idx_t        cand;
        logic        found;
        int unsigned pos;
        sel   = start;
        found = 1'b0;
        for (int unsigned k = 0; k < NoMst; k++) begin
            pos  = (int'(start) + k) % NoMst;
            cand = idx_t'(pos);
            if (!found && valid[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign gnt     = lock_q ? gnt_q : rr_select(slv_req_valid, rr_q);
    assign rr_next = (gnt == idx_t'(NoMst - 1)) ? '0 : gnt + 1'b1;

    // Request path: forward the granted requester unmodified; reset blanks the handshake.
    assign mst_req       = slv_req[gnt];
    assign mst_req_valid = rst_ni & slv_req_valid[gnt] & ~full;
    assign accept        = mst_req_valid & mst_req_ready;

    // Only the granted requester ever sees ready.
    always_comb begin
        slv_req_ready      = '0;
        slv_req_ready[gnt] = rst_ni & mst_req_ready & ~full;
    end

    // Response path: the oldest outstanding source index owns the current response.
    assign has_head      = ~empty;
    assign mst_rsp_ready = slv_rsp_ready[head] & has_head;
    assign pop           = mst_rsp_valid & mst_rsp_ready;

    // Response payload fans out to all ports; only the owner gets valid.
    always_comb begin
        for (int unsigned i = 0; i < NoMst; i++) begin
            slv_rsp[i] = mst_rsp;
        end
        slv_rsp_valid       = '0;
        slv_rsp_valid[head] = mst_rsp_valid & has_head;
    end

    // Priority pointer and grant lock: the grant is frozen while a forwarded request waits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            gnt_q  <= '0;
        end else if (accept) begin
            rr_q   <= rr_next;
            lock_q <= 1'b0;
        end else if (mst_req_valid) begin
            lock_q <= 1'b1;
            gnt_q  <= gnt;
        end
    end

    xadac_idx_fifo #(
        .Width (IdxW),
        .Depth (Depth)
    ) u_src_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (accept),
        .push_dat (gnt),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // A response with nothing outstanding has no owner and is dropped.
    a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mst_rsp_valid |-> has_head);

    // A requester holding the locked grant must keep its request up until accepted.
    a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> slv_req_valid[gnt_q]);

endmodule
